// File: rtl/mvp_arbiter.sv
// Round-robin scheduler sharing one 4x4 matrix-vector engine among NUM_REQ requesters.
// Grant to rsp_valid is engine latency + 2 cycles; each stage holds until its handshake, and a watchdog latches err.
module mvp_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DW             = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*16*DW-1:0]   req_mat,
   input  logic [NUM_REQ*4*DW-1:0]    req_vec,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [4*DW-1:0]            rsp_product,
   output logic                       eng_i_valid,
   input  logic                       eng_i_ready,
   output logic [16*DW-1:0]           eng_mat,
   output logic [4*DW-1:0]            eng_vec,
   input  logic                       eng_o_valid,
   output logic                       eng_o_ready,
   input  logic [4*DW-1:0]            eng_product,
   output logic                       err,
   output logic [$clog2(NUM_REQ)-1:0] owner
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_RETURN = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t        state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant;
   logic          grant_vld;
   logic [WW-1:0] wd;
   logic [IW-1:0] next_ptr;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int idx;
      grant     = '0;
      grant_vld = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_vld && req_valid[IW'(idx)]) begin
            grant     = IW'(idx);
            grant_vld = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && grant_vld) req_ready[grant] = 1'b1;
   end

   always_comb begin
      rsp_valid = '0;
      if (state == S_RETURN) rsp_valid[owner] = 1'b1;
   end

   assign eng_i_valid = (state == S_ISSUE);
   assign eng_o_ready = (state == S_WAIT);
   assign next_ptr    = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         owner       <= '0;
         err         <= 1'b0;
         wd          <= '0;
         eng_mat     <= '0;
         eng_vec     <= '0;
         rsp_product <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  eng_mat <= req_mat[int'(grant)*16*DW +: 16*DW];
                  eng_vec <= req_vec[int'(grant)*4*DW +: 4*DW];
                  owner   <= grant;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (eng_i_ready) begin
                  wd    <= '0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               wd <= wd + WW'(1);
               // A result arriving on the timeout cycle still counts as success.
               if (eng_o_valid) begin
                  rsp_product <= eng_product;
                  state       <= S_RETURN;
               end else if (wd == WW'(TIMEOUT_CYCLES)) begin
                  err   <= 1'b1;
                  state <= S_ERROR;
               end
            end
            S_RETURN: begin
               if (rsp_ready[owner]) begin
                  rr_ptr <= next_ptr;
                  state  <= S_IDLE;
               end
            end
            S_ERROR: err <= 1'b1;
            default: begin
               err   <= 1'b1;
               state <= S_ERROR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mvp_arbiter.sv
// Bench for mvp_arbiter with a behavioural stand-in engine and an expected-response queue.
module tb_mvp_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int T  = 40;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [N-1:0]          req_valid = '0;
   logic [N-1:0]          req_ready;
   logic [N*16*DW-1:0]    req_mat = '0;
   logic [N*4*DW-1:0]     req_vec = '0;
   logic [N-1:0]          rsp_valid;
   logic [N-1:0]          rsp_ready = '1;
   logic [4*DW-1:0]       rsp_product;
   logic                  eng_i_valid;
   logic                  eng_i_ready;
   logic [16*DW-1:0]      eng_mat;
   logic [4*DW-1:0]       eng_vec;
   logic                  eng_o_valid = 1'b0;
   logic                  eng_o_ready;
   logic [4*DW-1:0]       eng_product = '0;
   logic                  err;
   logic [1:0]            owner;

   mvp_arbiter #(.NUM_REQ(N), .DW(DW), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_mat(req_mat), .req_vec(req_vec),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
      .eng_i_valid(eng_i_valid), .eng_i_ready(eng_i_ready),
      .eng_mat(eng_mat), .eng_vec(eng_vec),
      .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_product(eng_product),
      .err(err), .owner(owner)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]    onehot;
      logic [4*DW-1:0] prod;
   } exp_t;

   exp_t            sb[$];
   logic [16*DW-1:0] mats [N];
   logic [4*DW-1:0]  vecs [N];
   int              nchk = 0;
   int              npass = 0;

   // Stand-in engine: gives the true product whenever the matrix is the identity.
   function automatic logic [4*DW-1:0] eng_f(input logic [16*DW-1:0] m, input logic [4*DW-1:0] v);
      logic [4*DW-1:0] p;
      for (int i = 0; i < 4; i++) p[i*DW +: DW] = v[i*DW +: DW] ^ m[5*i*DW +: DW] ^ 16'h3C00;
      return p;
   endfunction

   int               phase = 0;
   int               cnt = 0;
   int               eng_lat = 2;
   bit               stall = 1'b0;
   bit               mute = 1'b0;
   logic             i_hs = 1'b0;
   logic             o_hs = 1'b0;
   logic [16*DW-1:0] m_c = '0;
   logic [4*DW-1:0]  v_c = '0;

   assign eng_i_ready = (phase == 0) && !stall;

   always @(posedge clk) begin
      i_hs <= eng_i_valid && eng_i_ready;
      o_hs <= eng_o_valid && eng_o_ready;
   end

   // Result appears eng_lat cycles after the accepting edge.
   always @(negedge clk) begin
      if (rst) begin
         phase       = 0;
         eng_o_valid = 1'b0;
      end else begin
         if (phase == 2 && o_hs) begin
            eng_o_valid = 1'b0;
            phase       = 0;
         end
         if (phase == 0 && i_hs) begin
            m_c = eng_mat; v_c = eng_vec; cnt = eng_lat; phase = 1;
         end
         if (phase == 1) begin
            if (cnt == 0) begin
               if (!mute) begin
                  eng_product = eng_f(m_c, v_c);
                  eng_o_valid = 1'b1;
                  phase       = 2;
               end
            end else cnt = cnt - 1;
         end
      end
   end

   task automatic set_req(input int k, input logic [16*DW-1:0] m, input logic [4*DW-1:0] v);
      req_mat[k*16*DW +: 16*DW] = m;
      req_vec[k*4*DW +: 4*DW]   = v;
      mats[k] = m;
      vecs[k] = v;
   endtask

   task automatic rand_req(input int k);
      logic [16*DW-1:0] m;
      logic [4*DW-1:0]  v;
      for (int e = 0; e < 16; e++) m[e*DW +: DW] = 16'($urandom);
      for (int e = 0; e < 4; e++) v[e*DW +: DW] = 16'($urandom);
      set_req(k, m, v);
   endtask

   task automatic push_exp(input int k);
      exp_t e;
      e.onehot = '0;
      e.onehot[k] = 1'b1;
      e.prod = eng_f(mats[k], vecs[k]);
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_rsp(input int bound, output bit got);
      got = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (|rsp_valid) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_oready(input int bound, output bit got);
      got = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (eng_o_ready) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   // Submit requester k's current operands as a single-cycle request.
   task automatic submit(input int k);
      @(negedge clk);
      req_valid = '0;
      req_valid[k] = 1'b1;
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      nchk++; if ({err, owner} !== 3'b000) $display("FAIL reset_err_owner: got %b want 000", {err, owner}); else npass++;
      nchk++; if ({req_ready, rsp_valid, eng_i_valid, eng_o_ready} !== '0)
         $display("FAIL reset_handshakes: got %b want 0", {req_ready, rsp_valid, eng_i_valid, eng_o_ready}); else npass++;
      nchk++; if ({eng_mat, eng_vec, rsp_product} !== '0) $display("FAIL reset_data: got nonzero want 0"); else npass++;
      req_valid = 4'b0110;
      #1;
      nchk++; if (req_ready !== 4'b0010) $display("FAIL reset_grant_from_0: got %b want 0010", req_ready); else npass++;
      req_valid = '0;
      @(negedge clk);
      nchk++; if (eng_i_valid !== 1'b0) $display("FAIL withdrawn_req: got %b want 0", eng_i_valid); else npass++;
   endtask

   task automatic test_single();
      logic [16*DW-1:0] ident = '0;
      exp_t e;
      bit got;
      for (int r = 0; r < 4; r++) ident[5*r*DW +: DW] = 16'h3C00;
      set_req(2, ident, {16'h4400, 16'h4200, 16'h4000, 16'h3C00});
      e.onehot = 4'b0100;
      e.prod   = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
      sb.push_back(e);
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      nchk++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else npass++;
      @(negedge clk);
      req_valid = '0;
      nchk++; if ({eng_i_valid, owner} !== 3'b110) $display("FAIL single_issue: got %b want 110", {eng_i_valid, owner}); else npass++;
      wait_rsp(20, got);
      e = sb.pop_front();
      nchk++; if (!got) $display("FAIL single_timeout: got no rsp_valid want one"); else npass++;
      nchk++; if (rsp_valid !== e.onehot) $display("FAIL single_owner: got %b want %b", rsp_valid, e.onehot); else npass++;
      nchk++; if (rsp_product !== e.prod) $display("FAIL single_product: got %h want %h", rsp_product, e.prod); else npass++;
      @(negedge clk);
   endtask

   task automatic test_saturation();
      exp_t e;
      bit got;
      do_reset();
      for (int k = 0; k < N; k++) rand_req(k);
      for (int i = 0; i < 6; i++) push_exp(i % N);
      req_valid = '1;
      for (int i = 0; i < 6; i++) begin
         wait_rsp(30, got);
         e = sb.pop_front();
         if (i == 5) req_valid = '0;
         nchk++; if (!got) $display("FAIL sat_timeout_%0d: got no rsp_valid want one", i); else npass++;
         nchk++; if (rsp_valid !== e.onehot) $display("FAIL sat_owner_%0d: got %b want %b", i, rsp_valid, e.onehot); else npass++;
         nchk++; if (rsp_product !== e.prod) $display("FAIL sat_product_%0d: got %h want %h", i, rsp_product, e.prod); else npass++;
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      exp_t e;
      bit got, ok;
      logic [16*DW-1:0] m0;
      logic [4*DW-1:0]  p0;
      do_reset();
      stall = 1'b1;
      rand_req(1);
      push_exp(1);
      submit(1);
      m0 = eng_mat;
      nchk++; if (eng_mat !== mats[1]) $display("FAIL bp_latched_mat: got %h want %h", eng_mat, mats[1]); else npass++;
      ok = eng_i_valid;
      repeat (5) begin
         @(negedge clk);
         ok = ok && (eng_i_valid === 1'b1) && (eng_mat === m0);
      end
      nchk++; if (!ok) $display("FAIL bp_issue_hold: got unstable want eng_i_valid=1 and stable eng_mat"); else npass++;
      stall = 1'b0;
      rsp_ready = 4'b1101;
      rand_req(0);
      req_valid = 4'b0001;
      wait_rsp(20, got);
      e = sb.pop_front();
      nchk++; if (!got) $display("FAIL bp_timeout: got no rsp_valid want one"); else npass++;
      nchk++; if (rsp_product !== e.prod) $display("FAIL bp_product: got %h want %h", rsp_product, e.prod); else npass++;
      p0 = rsp_product;
      ok = 1'b1;
      repeat (7) begin
         @(negedge clk);
         ok = ok && (rsp_valid === e.onehot) && (rsp_product === p0) && (req_ready === '0) && (eng_i_valid === 1'b0);
      end
      nchk++; if (!ok) $display("FAIL bp_rsp_hold: got rsp_valid=%b req_ready=%b want %b 0000", rsp_valid, req_ready, e.onehot); else npass++;
      req_valid = '0;
      rsp_ready = '1;
      @(negedge clk);
      nchk++; if (rsp_valid !== '0) $display("FAIL bp_release: got %b want 0000", rsp_valid); else npass++;
   endtask

   task automatic test_timeout();
      exp_t e;
      bit got;
      do_reset();
      mute = 1'b1;
      rand_req(0);
      rand_req(1);
      submit(0);
      req_valid = 4'b0010;
      wait_oready(20, got);
      nchk++; if (!got) $display("FAIL to_enter_wait: got no eng_o_ready want one"); else npass++;
      repeat (T) @(negedge clk);
      nchk++; if (err !== 1'b0) $display("FAIL to_early: got err=%b want 0", err); else npass++;
      @(negedge clk);
      nchk++; if (err !== 1'b1) $display("FAIL to_rise: got err=%b want 1", err); else npass++;
      nchk++; if ({req_ready, rsp_valid, eng_i_valid, eng_o_ready} !== '0)
         $display("FAIL to_outputs: got %b want 0", {req_ready, rsp_valid, eng_i_valid, eng_o_ready}); else npass++;
      repeat (3) @(negedge clk);
      nchk++; if (err !== 1'b1) $display("FAIL to_sticky: got err=%b want 1", err); else npass++;
      mute = 1'b0;
      do_reset();
      #1;
      nchk++; if (err !== 1'b0) $display("FAIL to_reset_clear: got err=%b want 0", err); else npass++;
      push_exp(1);
      submit(1);
      wait_rsp(20, got);
      e = sb.pop_front();
      nchk++; if (!got || rsp_valid !== e.onehot) $display("FAIL to_recover_owner: got %b want %b", rsp_valid, e.onehot); else npass++;
      nchk++; if (rsp_product !== e.prod) $display("FAIL to_recover_product: got %h want %h", rsp_product, e.prod); else npass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit got, quiet;
      do_reset();
      rand_req(1);
      push_exp(1);
      submit(1);
      wait_rsp(20, got);
      e = sb.pop_front();
      nchk++; if (!got || rsp_valid !== e.onehot) $display("FAIL mid_first_job: got %b want %b", rsp_valid, e.onehot); else npass++;
      eng_lat = 10;
      submit(1);
      wait_oready(20, got);
      nchk++; if (!got) $display("FAIL mid_enter_wait: got no eng_o_ready want one"); else npass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      quiet = 1'b1;
      repeat (15) begin
         @(negedge clk);
         quiet = quiet && (rsp_valid === '0) && (eng_o_ready === 1'b0);
      end
      nchk++; if (!quiet) $display("FAIL mid_dropped: got rsp_valid=%b want 0000", rsp_valid); else npass++;
      eng_lat = 2;
      req_valid = '1;
      #1;
      nchk++; if (req_ready !== 4'b0001) $display("FAIL mid_rr_ptr: got %b want 0001", req_ready); else npass++;
      req_valid = '0;
      rand_req(3);
      push_exp(3);
      submit(3);
      wait_rsp(20, got);
      e = sb.pop_front();
      nchk++; if (!got || rsp_valid !== e.onehot) $display("FAIL mid_req3_owner: got %b want %b", rsp_valid, e.onehot); else npass++;
      nchk++; if (rsp_product !== e.prod) $display("FAIL mid_req3_product: got %h want %h", rsp_product, e.prod); else npass++;
      @(negedge clk);
   endtask

   task automatic test_tie();
      exp_t e;
      bit got;
      do_reset();
      eng_lat = T;
      rand_req(2);
      push_exp(2);
      submit(2);
      wait_rsp(T + 20, got);
      e = sb.pop_front();
      nchk++; if (!got || rsp_valid !== e.onehot) $display("FAIL tie_owner: got %b want %b", rsp_valid, e.onehot); else npass++;
      nchk++; if (rsp_product !== e.prod) $display("FAIL tie_product: got %h want %h", rsp_product, e.prod); else npass++;
      nchk++; if (err !== 1'b0) $display("FAIL tie_err: got %b want 0", err); else npass++;
      @(negedge clk);
      nchk++; if ({err, rsp_valid} !== 5'b0) $display("FAIL tie_after: got %b want 00000", {err, rsp_valid}); else npass++;
      eng_lat = 2;
   endtask

   initial begin
      test_reset();
      test_single();
      test_saturation();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_tie();
      nchk++; if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); else npass++;
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
